// File: rtl/capture_writer.sv
// ---------------------------------------------------------------------------
// capture_writer
//   Buffers 256-bit compressed words in a small FIFO and writes them to
//   memory as Avalon-MM bursts. The destination is a region
//   [base_addr, limit_addr) of word addresses. It is used either as a
//   circular buffer (wrap_en=1) or as a one-shot region (wrap_en=0).
//
// Ports
//   clk, rst_n         : clock and asynchronous active-low reset
//   start / stop       : single-cycle pulses that arm and end a capture
//   wrap_en, base_addr,
//   limit_addr         : region setup, sampled on an accepted start
//   in_valid, in_data  : source words (no backpressure, dropped when full)
//   avm_*              : Avalon-MM burst write master
//   busy, done         : capture status
//   overflow, wrapped  : sticky event flags, cleared on start
//   words_written      : beats completed since the last start
// ---------------------------------------------------------------------------
module capture_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_LEN  = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              wrap_en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] limit_addr,
  input  logic              in_valid,
  input  logic [255:0]      in_data,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [255:0]      avm_writedata,
  output logic [3:0]        avm_burstcount,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              wrapped,
  output logic [63:0]       words_written
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_BURST = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Region and capture control registers
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_limit;
  logic              r_wrap;
  logic [ADDR_W-1:0] r_ptr;
  logic [3:0]        r_len;
  logic [3:0]        r_beat;
  logic              r_stop_pend;
  logic              r_overflow;
  logic              r_wrapped;
  logic [63:0]       r_words;

  // FIFO storage and pointers
  logic [255:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_rd;
  logic [PW-1:0]     r_wr;
  logic [CW-1:0]     r_count;

  logic [ADDR_W-1:0] w_room;
  logic [ADDR_W-1:0] w_cap;
  logic [ADDR_W-1:0] w_len_full;
  logic [3:0]        w_len;
  logic              w_burst_ready;
  logic              w_pop;
  logic              w_last_beat;
  logic [ADDR_W-1:0] w_ptr_end;
  logic              w_hit_limit;
  logic              w_full;
  logic              w_accept;
  logic              w_push;
  logic              w_drop;
  logic              w_start;
  logic              w_stop;
  logic              w_burst_go;
  logic              w_enter_done;

  // Burst sizing: never past the region end, never more than is buffered.
  // w_cap is the largest burst the current pointer allows. RUN launches as
  // soon as that much is buffered, so a short tail burst just below
  // limit_addr does not wait for BURST_LEN words that could not be written
  // there anyway.
  always_comb begin
    w_room = r_limit - r_ptr;
    w_cap  = ADDR_W'(BURST_LEN);
    if (w_room < w_cap) begin
      w_cap = w_room;
    end
    w_len_full = w_cap;
    if (ADDR_W'(r_count) < w_len_full) begin
      w_len_full = ADDR_W'(r_count);
    end
    w_len         = w_len_full[3:0];
    w_burst_ready = (ADDR_W'(r_count) >= w_cap);
  end

  assign w_pop       = (r_state == S_BURST) && !avm_waitrequest;
  assign w_last_beat = w_pop && (r_beat == (r_len - 4'd1));
  assign w_ptr_end   = r_ptr + ADDR_W'(r_len);
  assign w_hit_limit = (w_ptr_end == r_limit);
  assign w_full      = (r_count == CW'(FIFO_DEPTH));

  // Input is taken only while capturing and not yet stopped. The stop cycle
  // itself still pushes, because r_stop_pend only rises after it.
  assign w_accept = ((r_state == S_RUN) || (r_state == S_BURST)) && !r_stop_pend;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_push   = in_valid && w_accept && (!w_full || w_pop);
  assign w_drop   = in_valid && w_accept && w_full && !w_pop;
  assign w_start  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_stop   = stop && ((r_state == S_RUN) || (r_state == S_BURST));

  assign w_burst_go   = (r_state != S_BURST) && (w_state_next == S_BURST);
  assign w_enter_done = (r_state == S_BURST) && (w_state_next == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and bus outputs. The bus outputs decode the state register
  // directly, so an asserted reset drops avm_write without waiting for a clock.
  always_comb begin
    w_state_next   = r_state;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_burstcount = '0;
    avm_writedata  = '0;
    busy           = 1'b0;
    done           = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        done = (r_state == S_DONE);
        if (w_start) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (stop) begin
          w_state_next = S_FLUSH;
        end else if (w_burst_ready) begin
          w_state_next = S_BURST;
        end
      end
      S_BURST: begin
        busy           = 1'b1;
        avm_write      = 1'b1;
        avm_address    = r_ptr;
        avm_burstcount = r_len;
        avm_writedata  = r_mem[r_rd];
        if (w_last_beat) begin
          if (w_hit_limit && !r_wrap) begin
            w_state_next = S_DONE;
          end else if (r_stop_pend || stop) begin
            w_state_next = S_FLUSH;
          end else begin
            w_state_next = S_RUN;
          end
        end
      end
      S_FLUSH: begin
        busy = 1'b1;
        if (r_count == '0) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_BURST;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Capture control, pointer and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base      <= '0;
      r_limit     <= '0;
      r_wrap      <= 1'b0;
      r_ptr       <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_stop_pend <= 1'b0;
      r_overflow  <= 1'b0;
      r_wrapped   <= 1'b0;
      r_words     <= '0;
    end else if (w_start) begin
      r_base      <= base_addr;
      r_limit     <= limit_addr;
      r_wrap      <= wrap_en;
      r_ptr       <= base_addr;
      r_stop_pend <= 1'b0;
      r_overflow  <= 1'b0;
      r_wrapped   <= 1'b0;
      r_words     <= '0;
    end else begin
      if (w_stop) begin
        r_stop_pend <= 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_burst_go) begin
        r_len  <= w_len;
        r_beat <= '0;
      end
      if (w_pop) begin
        r_words <= r_words + 64'd1;
        r_beat  <= r_beat + 4'd1;
      end
      if (w_last_beat) begin
        if (w_hit_limit && r_wrap) begin
          r_ptr     <= r_base;
          r_wrapped <= 1'b1;
        end else begin
          r_ptr <= w_ptr_end;
        end
      end
    end
  end

  // FIFO pointers; emptied on start and when a one-shot region fills up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (w_start || w_enter_done) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + PW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Storage array has no reset; only slots behind r_wr are ever read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= in_data;
    end
  end

  assign overflow      = r_overflow;
  assign wrapped       = r_wrapped;
  assign words_written = r_words;

endmodule

// File: tb/tb_capture_writer.sv
// ---------------------------------------------------------------------------
// tb_capture_writer
//   Table-driven bench for capture_writer. Each record describes one capture
//   (region, words fed, stop style) and the bursts and status it must
//   produce. A hand-written sequence covers reset asserted mid-burst.
// ---------------------------------------------------------------------------
module tb_capture_writer;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         stop;
  logic         wrap_en;
  logic [31:0]  base_addr;
  logic [31:0]  limit_addr;
  logic         in_valid;
  logic [255:0] in_data;
  logic [31:0]  avm_address;
  logic         avm_write;
  logic [255:0] avm_writedata;
  logic [3:0]   avm_burstcount;
  logic         avm_waitrequest;
  logic         busy;
  logic         done;
  logic         overflow;
  logic         wrapped;
  logic [63:0]  words_written;

  capture_writer #(.FIFO_DEPTH(16), .BURST_LEN(8), .ADDR_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stop           (stop),
    .wrap_en        (wrap_en),
    .base_addr      (base_addr),
    .limit_addr     (limit_addr),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .avm_address    (avm_address),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_burstcount (avm_burstcount),
    .avm_waitrequest(avm_waitrequest),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow),
    .wrapped        (wrapped),
    .words_written  (words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [255:0] word(input int s, input int i);
    logic [31:0] w;
    w = 32'(s * 4096 + i + 1) ^ 32'hA5A5_0000;
    return {w, ~w, w, ~w, w, ~w, w, ~w};
  endfunction

  // Bus monitor: one entry per burst (address, count) and one per beat
  logic [31:0]  mon_addr_q[$];
  int           mon_cnt_q[$];
  logic [255:0] mon_data_q[$];
  int           mon_rem;
  logic [31:0]  mon_cur_addr;
  int           mon_cur_cnt;
  int           mon_err;

  initial begin
    mon_rem = 0;
    mon_err = 0;
    mon_cur_addr = '0;
    mon_cur_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_rem = 0;
      end else begin
        if (mon_rem > 0 && !avm_write) mon_err++;
        if (avm_write) begin
          if (mon_rem == 0) begin
            mon_addr_q.push_back(avm_address);
            mon_cnt_q.push_back(int'(avm_burstcount));
            mon_cur_addr = avm_address;
            mon_cur_cnt  = int'(avm_burstcount);
            mon_rem      = int'(avm_burstcount);
            if (avm_burstcount == 4'd0) mon_err++;
          end else if (avm_address != mon_cur_addr || int'(avm_burstcount) != mon_cur_cnt) begin
            mon_err++;
          end
          if (!avm_waitrequest) begin
            mon_data_q.push_back(avm_writedata);
            mon_rem--;
          end
        end
      end
    end
  end

  typedef struct {
    logic [31:0]      base;
    logic [31:0]      limit;
    bit               wrap;
    int               nwords;
    bit               hold;        // waitrequest held high while feeding
    bit               stop_after;  // stop pulse in the cycle after the last word
    bit               stop_last;   // stop pulse together with the last word
    int               extra;       // words offered after the stop
    int               nb;
    logic [3:0][31:0] addr;        // index 0 = first burst
    logic [3:0][3:0]  cnt;
    int               written;
    bit               exp_done;
    bit               exp_wrapped;
    bit               exp_ovf;
    bit               exp_busy;
  } vec_t;

  vec_t tv[8];

  task automatic clear_mon();
    mon_addr_q.delete();
    mon_cnt_q.delete();
    mon_data_q.delete();
    mon_err = 0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    avm_waitrequest = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_rst_flags"}, 256'({avm_write, busy, done, overflow, wrapped, avm_burstcount}), 256'd0);
    check({tag, "_rst_addr"}, 256'(avm_address), 256'd0);
    check({tag, "_rst_words"}, 256'(words_written), 256'd0);
    check({tag, "_rst_wdata"}, avm_writedata, 256'd0);
    clear_mon();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [31:0] l, input bit w);
    base_addr  = b;
    limit_addr = l;
    wrap_en    = w;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input int k);
    string tag;
    tag = $sformatf("v%0d", k);
    do_reset(tag);
    do_start(tv[k].base, tv[k].limit, tv[k].wrap);
    for (int i = 0; i < tv[k].nwords; i++) begin
      in_valid = 1'b1;
      in_data = word(k, i);
      avm_waitrequest = tv[k].hold;
      stop = tv[k].stop_last && (i == tv[k].nwords - 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    stop = 1'b0;
    if (tv[k].stop_after) begin
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
    end
    for (int e = 0; e < tv[k].extra; e++) begin
      in_valid = 1'b1;
      in_data = word(k, 100 + e);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    avm_waitrequest = 1'b0;
    repeat (80) @(posedge clk);
    @(negedge clk);
    #1;
    check({tag, "_nbursts"}, 256'(mon_addr_q.size()), 256'(tv[k].nb));
    for (int b = 0; b < tv[k].nb; b++) begin
      if (b < mon_addr_q.size()) begin
        check($sformatf("%s_addr%0d", tag, b), 256'(mon_addr_q[b]), 256'(tv[k].addr[b]));
        check($sformatf("%s_cnt%0d", tag, b), 256'(mon_cnt_q[b]), 256'(tv[k].cnt[b]));
      end
    end
    check({tag, "_nbeats"}, 256'(mon_data_q.size()), 256'(tv[k].written));
    for (int j = 0; j < tv[k].written; j++) begin
      if (j < mon_data_q.size()) begin
        check($sformatf("%s_data%0d", tag, j), mon_data_q[j], word(k, j));
      end
    end
    check({tag, "_words"}, 256'(words_written), 256'(tv[k].written));
    check({tag, "_done"}, 256'(done), 256'(tv[k].exp_done));
    check({tag, "_busy"}, 256'(busy), 256'(tv[k].exp_busy));
    check({tag, "_wrapped"}, 256'(wrapped), 256'(tv[k].exp_wrapped));
    check({tag, "_overflow"}, 256'(overflow), 256'(tv[k].exp_ovf));
    check({tag, "_bus_protocol"}, 256'(mon_err), 256'd0);
    $display("vec %0d: bursts=%0d beats=%0d words_written=%0d done=%0b wrapped=%0b overflow=%0b",
             k, mon_addr_q.size(), mon_data_q.size(), words_written, done, wrapped, overflow);
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    wrap_en = 1'b0;
    base_addr = '0;
    limit_addr = '0;
    in_valid = 1'b0;
    in_data = '0;
    avm_waitrequest = 1'b0;

    //         base      limit     wrap  n  hold sa  sl  ex nb  addresses (last..first)                      counts (last..first)          wr  done wrp ovf busy
    tv[0] = '{32'h100, 32'h200, 1'b0, 16, 1'b0, 1'b0, 1'b0, 0, 2, {32'h0, 32'h0, 32'h108, 32'h100}, {4'd0, 4'd0, 4'd8, 4'd8}, 16, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[1] = '{32'h100, 32'h200, 1'b0,  5, 1'b0, 1'b1, 1'b0, 0, 1, {32'h0, 32'h0, 32'h0, 32'h100},   {4'd0, 4'd0, 4'd0, 4'd5},  5, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[2] = '{32'h0,   32'd12,  1'b1, 24, 1'b0, 1'b0, 1'b0, 0, 4, {32'h8, 32'h0, 32'h8, 32'h0},     {4'd4, 4'd8, 4'd4, 4'd8}, 24, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[3] = '{32'h100, 32'h200, 1'b0, 20, 1'b1, 1'b0, 1'b0, 0, 2, {32'h0, 32'h0, 32'h108, 32'h100}, {4'd0, 4'd0, 4'd8, 4'd8}, 16, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[4] = '{32'h100, 32'h108, 1'b0, 12, 1'b0, 1'b0, 1'b0, 0, 1, {32'h0, 32'h0, 32'h0, 32'h100},   {4'd0, 4'd0, 4'd0, 4'd8},  8, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[5] = '{32'h100, 32'h200, 1'b0, 10, 1'b0, 1'b1, 1'b0, 0, 2, {32'h0, 32'h0, 32'h108, 32'h100}, {4'd0, 4'd0, 4'd2, 4'd8}, 10, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[6] = '{32'h100, 32'h200, 1'b0,  0, 1'b0, 1'b1, 1'b0, 0, 0, {32'h0, 32'h0, 32'h0, 32'h0},     {4'd0, 4'd0, 4'd0, 4'd0},  0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[7] = '{32'h100, 32'h200, 1'b0,  3, 1'b0, 1'b0, 1'b1, 2, 1, {32'h0, 32'h0, 32'h0, 32'h100},   {4'd0, 4'd0, 4'd0, 4'd3},  3, 1'b1, 1'b0, 1'b0, 1'b0};

    for (int k = 0; k < 8; k++) begin
      run_vec(k);
    end

    // Reset asserted during beat 3 of an 8-beat burst, then a fresh capture
    do_reset("h");
    do_start(32'h40, 32'h1000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = word(9, i);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    t = 0;
    while (mon_data_q.size() < 2 && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("h_reach_beat2", 256'(t < 50), 256'd1);
    @(posedge clk);
    #2;
    check("h_beat3_write", 256'(avm_write), 256'd1);
    check("h_beat3_words", 256'(words_written), 256'd2);
    rst_n = 1'b0;
    #1;
    check("h_async_write", 256'(avm_write), 256'd0);
    check("h_async_flags", 256'({busy, done, overflow, wrapped, avm_burstcount}), 256'd0);
    check("h_async_addr", 256'(avm_address), 256'd0);
    check("h_async_wdata", avm_writedata, 256'd0);
    check("h_async_words", 256'(words_written), 256'd0);
    $display("mid-burst reset: avm_write=%0b words_written=%0d", avm_write, words_written);
    @(negedge clk);
    #1;
    clear_mon();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_start(32'h200, 32'h300, 1'b0);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = word(10, i);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    #1;
    check("h_re_nbursts", 256'(mon_addr_q.size()), 256'd1);
    if (mon_addr_q.size() > 0) begin
      check("h_re_addr", 256'(mon_addr_q[0]), 256'h200);
      check("h_re_cnt", 256'(mon_cnt_q[0]), 256'd8);
    end
    check("h_re_nbeats", 256'(mon_data_q.size()), 256'd8);
    for (int j = 0; j < 8; j++) begin
      if (j < mon_data_q.size()) begin
        check($sformatf("h_re_data%0d", j), mon_data_q[j], word(10, j));
      end
    end
    check("h_re_words", 256'(words_written), 256'd8);
    check("h_re_busy", 256'(busy), 256'd1);
    check("h_re_protocol", 256'(mon_err), 256'd0);
    $display("restart: bursts=%0d beats=%0d words_written=%0d", mon_addr_q.size(), mon_data_q.size(), words_written);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
